// File: rtl/io_input_port.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_port
//  Description : Input-side peripheral on the MIPS IO bus. Synchronises and
//                debounces slide switches and push buttons, latches sticky
//                button press events, counts presses on button 0 and returns
//                all of it on IOReadData, decoded from IOAddr.
//
//  Ports       : CLK          system clock (10 MHz divided clock)
//                RESETN       asynchronous active-low reset
//                SW[NSW]      raw slide switches (asynchronous)
//                BTN[NBTN]    raw push buttons, active-high (asynchronous)
//                IOAddr[4]    processor IO address
//                IOWriteEn    processor IO write strobe (one cycle)
//                IOWriteData  processor IO write data
//                IOReadData   combinational read data
//                IRQ          registered OR of (EVT & MASK), only when
//                             IO_INPUT_IRQ_EN is defined
//
//  Register map: 4'h4 R   debounced switches
//                4'h8 R/W EVT sticky press flags, write-1-to-clear
//                4'hA R/W MASK interrupt mask (IO_INPUT_IRQ_EN only)
//                4'hC R/W PCNT saturating press counter for button 0
//
//  Config      : `define IO_INPUT_IRQ_EN to add the IRQ output and MASK.
//
//  Revision    : 1.0  initial release
// ============================================================================
module io_input_port #(
    parameter int NSW       = 2,
    parameter int NBTN      = 4,
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = 16
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [NSW-1:0]  SW,
    input  logic [NBTN-1:0] BTN,
    input  logic [3:0]      IOAddr,
    input  logic            IOWriteEn,
    input  logic [31:0]     IOWriteData,
`ifdef IO_INPUT_IRQ_EN
    output logic            IRQ,
`endif
    output logic [31:0]     IOReadData
);

    localparam int                c_N       = NSW + NBTN;
    localparam int                c_DB_W    = $clog2(DB_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser over all pins; switches in the low bits,
    // buttons above them.
    // ------------------------------------------------------------------
    logic [c_N-1:0] r_sync1;
    logic [c_N-1:0] r_sync2;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {BTN, SW};
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debouncer: the level is accepted only after DB_CYCLES
    // consecutive cycles of disagreement with the current debounced value.
    // ------------------------------------------------------------------
    logic [c_N-1:0] w_db;

    for (genvar gi = 0; gi < c_N; gi++) begin : g_db
        logic [c_DB_W-1:0] r_cnt;
        logic              r_db;

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_sync2[gi] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_db  <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_DB_ONE;
            end
        end

        assign w_db[gi] = r_db;
    end

    logic [NSW-1:0]  w_db_sw;
    logic [NBTN-1:0] w_db_btn;

    assign w_db_sw  = w_db[NSW-1:0];
    assign w_db_btn = w_db[c_N-1:NSW];

    // ------------------------------------------------------------------
    // Rising-edge detect on debounced buttons
    // ------------------------------------------------------------------
    logic [NBTN-1:0] r_btn_q;
    logic [NBTN-1:0] w_rise;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_btn_q <= '0;
        end else begin
            r_btn_q <= w_db_btn;
        end
    end

    assign w_rise = w_db_btn & ~r_btn_q;

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    logic w_wr_evt;
    logic w_wr_cnt;

    assign w_wr_evt = IOWriteEn && (IOAddr == 4'h8);
    assign w_wr_cnt = IOWriteEn && (IOAddr == 4'hC);

    // Sticky flags: the rise term is ORed in after the clear so that a
    // press landing on the same cycle as its clear is never lost.
    logic [NBTN-1:0] r_evt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_evt <= '0;
        end else if (w_wr_evt) begin
            r_evt <= (r_evt & ~IOWriteData[NBTN-1:0]) | w_rise;
        end else begin
            r_evt <= r_evt | w_rise;
        end
    end

    // Saturating press counter; a software load takes priority over a press.
    logic [CNT_W-1:0] r_pcnt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_pcnt <= '0;
        end else if (w_wr_cnt) begin
            r_pcnt <= IOWriteData[CNT_W-1:0];
        end else if (w_rise[0] && (r_pcnt != '1)) begin
            r_pcnt <= r_pcnt + c_CNT_ONE;
        end
    end

`ifdef IO_INPUT_IRQ_EN
    // ------------------------------------------------------------------
    // Interrupt mask and registered interrupt request
    // ------------------------------------------------------------------
    logic [NBTN-1:0] r_mask;
    logic            r_irq;
    logic            w_wr_mask;

    assign w_wr_mask = IOWriteEn && (IOAddr == 4'hA);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= IOWriteData[NBTN-1:0];
            end
            r_irq <= |(r_evt & r_mask);
        end
    end

    assign IRQ = r_irq;
`endif

    // Only the low field bits of the write bus are used per register.
    logic w_unused_wdata;
    assign w_unused_wdata = ^IOWriteData;

    // ------------------------------------------------------------------
    // Read mux, zero-extended
    // ------------------------------------------------------------------
    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            4'h4:    IOReadData[NSW-1:0]   = w_db_sw;
            4'h8:    IOReadData[NBTN-1:0]  = r_evt;
            4'hC:    IOReadData[CNT_W-1:0] = r_pcnt;
`ifdef IO_INPUT_IRQ_EN
            4'hA:    IOReadData[NBTN-1:0]  = r_mask;
`endif
            default: IOReadData = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_input_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_input_port
//  Description : Self-checking bench for io_input_port. A cycle-level
//                reference model built from the debounce/event/counter rules
//                predicts every read and IRQ; directed sequences cover the
//                reset, glitch, clear and saturation cases, followed by a
//                randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_input_port;

    localparam int NSW   = 2;
    localparam int NBTN  = 4;
    localparam int DB    = 4;
    localparam int CNT_W = 4;
    localparam int NP    = NSW + NBTN;

    logic              CLK;
    logic              RESETN;
    logic [NSW-1:0]    SW;
    logic [NBTN-1:0]   BTN;
    logic [3:0]        IOAddr;
    logic              IOWriteEn;
    logic [31:0]       IOWriteData;
    logic [31:0]       IOReadData;
`ifdef IO_INPUT_IRQ_EN
    logic              IRQ;
`endif

    io_input_port #(
        .NSW       (NSW),
        .NBTN      (NBTN),
        .DB_CYCLES (DB),
        .CNT_W     (CNT_W)
    ) u_dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .SW          (SW),
        .BTN         (BTN),
        .IOAddr      (IOAddr),
        .IOWriteEn   (IOWriteEn),
        .IOWriteData (IOWriteData),
`ifdef IO_INPUT_IRQ_EN
        .IRQ         (IRQ),
`endif
        .IOReadData  (IOReadData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Pins are recorded per edge; a pin value is seen by
    // the debouncer two edges after it is sampled, and a debounced level
    // flips once the last DB observed values all disagree with it.
    // ------------------------------------------------------------------
    logic [NP-1:0]    m_pins[$];
    logic [NP-1:0]    m_win[$];
    logic [NP-1:0]    m_db     = '0;
    logic [NP-1:0]    m_dbprev = '0;
    logic [NBTN-1:0]  m_evt    = '0;
    logic [CNT_W-1:0] m_pcnt   = '0;
    logic [NBTN-1:0]  m_mask   = '0;
    logic             m_irq    = 1'b0;

    task automatic model_step();
        logic [NP-1:0]   seen;
        logic [NP-1:0]   ndb;
        logic [NBTN-1:0] rise;
        logic            irq_next;
        bit              flip;
        seen = (m_pins.size() >= 2) ? m_pins[m_pins.size()-2] : '0;
        m_pins.push_back({BTN, SW});
        if (m_pins.size() > 3) void'(m_pins.pop_front());
        m_win.push_back(seen);
        if (m_win.size() > DB) void'(m_win.pop_front());

        rise     = m_db[NP-1:NSW] & ~m_dbprev[NP-1:NSW];
        irq_next = |(m_evt & m_mask);

        ndb = m_db;
        if (m_win.size() == DB) begin
            for (int b = 0; b < NP; b++) begin
                flip = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (m_win[k][b] == m_db[b]) flip = 1'b0;
                if (flip) ndb[b] = ~m_db[b];
            end
        end

        if (IOWriteEn && IOAddr == 4'h8) m_evt = m_evt & ~IOWriteData[NBTN-1:0];
        m_evt = m_evt | rise;

        if (IOWriteEn && IOAddr == 4'hC) m_pcnt = IOWriteData[CNT_W-1:0];
        else if (rise[0] && m_pcnt != 4'hF) m_pcnt = m_pcnt + 4'd1;

`ifdef IO_INPUT_IRQ_EN
        if (IOWriteEn && IOAddr == 4'hA) m_mask = IOWriteData[NBTN-1:0];
`endif
        m_irq    = irq_next;
        m_dbprev = m_db;
        m_db     = ndb;
    endtask

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_pins.delete();
            m_win.delete();
            m_db     = '0;
            m_dbprev = '0;
            m_evt    = '0;
            m_pcnt   = '0;
            m_mask   = '0;
            m_irq    = 1'b0;
        end else begin
            model_step();
        end
    end

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a)
            4'h4:    return {30'd0, m_db[NSW-1:0]};
            4'h8:    return {28'd0, m_evt};
            4'hC:    return {28'd0, m_pcnt};
`ifdef IO_INPUT_IRQ_EN
            4'hA:    return {28'd0, m_mask};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One cycle: drive at the falling edge, compare shortly after.
    task automatic step(input logic [1:0] sw, input logic [3:0] btn, input logic [3:0] addr,
                        input logic we, input logic [31:0] wd);
        @(negedge CLK);
        SW          = sw;
        BTN         = btn;
        IOAddr      = addr;
        IOWriteEn   = we;
        IOWriteData = wd;
        #1;
        check("rd", IOReadData, exp_read(addr));
`ifdef IO_INPUT_IRQ_EN
        check("irq", {31'd0, IRQ}, {31'd0, m_irq});
`endif
    endtask

    // Hold one button for 'hold' cycles, then release it long enough to settle.
    task automatic press(input int b, input int hold);
        for (int i = 0; i < hold; i++) step(2'b00, 4'(1 << b), 4'h8, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++)    step(2'b00, 4'h0, 4'h8, 1'b0, 32'd0);
    endtask

    logic [1:0]  r_sw;
    logic [3:0]  r_btn;
    logic [3:0]  r_addr;
    logic [3:0]  addr_tbl [6];

    initial begin
        RESETN      = 1'b0;
        SW          = 2'b11;
        BTN         = '0;
        IOAddr      = 4'h4;
        IOWriteEn   = 1'b0;
        IOWriteData = '0;

        // Switches held high through reset must not appear.
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 4'h0, 4'h4, 1'b0, 32'd0);
            check("rst_sw", IOReadData, 32'h0);
        end
        @(negedge CLK);
        RESETN = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(2'b11, 4'h0, 4'h4, 1'b0, 32'd0);
            check("sw_latency", IOReadData, (k == 6) ? 32'h3 : 32'h0);
        end

        // Short glitch on BTN[1] is rejected; a long press is latched.
        press(1, 3);
        check("glitch_evt", IOReadData, 32'h0);
        press(1, 10);
        check("press_evt", IOReadData, 32'h2);

        // Write-1-to-clear, and set winning over a simultaneous clear.
        press(2, 8);
        check("evt_0110", IOReadData, 32'h6);
        step(2'b00, 4'h0, 4'h8, 1'b1, 32'h2);
        step(2'b00, 4'h0, 4'h8, 1'b0, 32'h0);
        check("evt_w1c", IOReadData, 32'h4);
        for (int k = 1; k <= 6; k++) step(2'b00, 4'h4, 4'h8, 1'b0, 32'd0);
        step(2'b00, 4'h4, 4'h8, 1'b1, 32'h4);
        step(2'b00, 4'h4, 4'h8, 1'b0, 32'h0);
        check("evt_set_wins", IOReadData, 32'h4);
        for (int i = 0; i < 8; i++) step(2'b00, 4'h0, 4'h8, 1'b0, 32'd0);

        // Press counter saturation, load and resumed counting.
        for (int p = 0; p < 17; p++) press(0, 8);
        step(2'b00, 4'h0, 4'hC, 1'b0, 32'd0);
        check("pcnt_sat", IOReadData, 32'hF);
        step(2'b00, 4'h0, 4'hC, 1'b1, 32'h3);
        step(2'b00, 4'h0, 4'hC, 1'b0, 32'h0);
        check("pcnt_load", IOReadData, 32'h3);
        for (int i = 0; i < 8; i++) step(2'b00, 4'h1, 4'hC, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) step(2'b00, 4'h0, 4'hC, 1'b0, 32'd0);
        check("pcnt_next", IOReadData, 32'h4);

        // Reset in the middle of a qualifying press.
        for (int i = 0; i < 4; i++) step(2'b00, 4'h1, 4'h8, 1'b0, 32'd0);
        @(negedge CLK);
        RESETN = 1'b0;
        IOAddr = 4'h8;
        #1;
        check("midrst_evt", IOReadData, 32'h0);
        IOAddr = 4'hC;
        #1;
        check("midrst_pcnt", IOReadData, 32'h0);
        for (int i = 0; i < 2; i++) step(2'b00, 4'h1, 4'h8, 1'b0, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        for (int k = 1; k <= 7; k++) step(2'b00, 4'h1, 4'h8, 1'b0, 32'd0);
        check("requal_evt", IOReadData, 32'h1);
        for (int i = 0; i < 8; i++) step(2'b00, 4'h0, 4'h8, 1'b0, 32'd0);

`ifdef IO_INPUT_IRQ_EN
        // Masked interrupt: only button 0 may raise IRQ.
        step(2'b00, 4'h0, 4'h8, 1'b1, 32'hF);
        step(2'b00, 4'h0, 4'hA, 1'b1, 32'h1);
        step(2'b00, 4'h0, 4'hA, 1'b0, 32'h0);
        check("mask_rd", IOReadData, 32'h1);
        press(1, 8);
        check("irq_unmasked", {31'd0, IRQ}, 32'h0);
        press(0, 8);
        check("irq_set", {31'd0, IRQ}, 32'h1);
        step(2'b00, 4'h0, 4'h8, 1'b1, 32'h1);
        step(2'b00, 4'h0, 4'h8, 1'b0, 32'h0);
        step(2'b00, 4'h0, 4'h8, 1'b0, 32'h0);
        check("irq_clr", {31'd0, IRQ}, 32'h0);
`endif

        // Randomized phase: pins change occasionally, random reads/writes.
        addr_tbl[0] = 4'h4;
        addr_tbl[1] = 4'h8;
        addr_tbl[2] = 4'hA;
        addr_tbl[3] = 4'hC;
        addr_tbl[4] = 4'h0;
        addr_tbl[5] = 4'h7;
        r_sw  = '0;
        r_btn = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) r_sw  = 2'($urandom);
            if ($urandom_range(0, 5) == 0) r_btn = 4'($urandom);
            r_addr = addr_tbl[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0)
                step(r_sw, r_btn, r_addr, 1'b1, $urandom);
            else
                step(r_sw, r_btn, r_addr, 1'b0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
